// File: rtl/sub86_dbus.sv
// sub86_dbus: data-side RAM plus peripheral page (TX FIFO, timer, GPIO, sticky error flags).
// Reads are combinational on A; writes commit on the rising CLK edge.
module sub86_dbus #(
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [31:0] A,
    input  logic [31:0] Q,
    input  logic        WEN,
    input  logic [1:0]  BEN,
    output logic [31:0] D,
    output logic [31:0] TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic [31:0] GPIO,
    output logic        ERR
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   ram [DEPTH_WORDS];
    logic [31:0]   fifo [FIFO_DEPTH];
    logic [1:0]    wp, rp;
    logic [2:0]    cnt;
    logic [31:0]   timer, gpio;
    logic          ovf, mis, ovf_n, mis_n;
    logic          periph, is32, is16, misal, wr, ram_we, push_req, push, pop, empty, full;
    logic          st_wr, tm_wr, gp_wr, unused_a;
    logic [AW-1:0] widx;
    logic [3:0]    lanes;
    logic [4:0]    sh;
    logic [31:0]   wdata, rword, rsh, ram_d, head, status;

    always_comb begin
        periph   = A[31:28] == 4'hF;
        is32     = BEN == 2'b01;
        is16     = BEN == 2'b11;
        misal    = is32 ? |A[1:0] : (is16 & A[0]);
        widx     = A[AW+1:2];
        sh       = {A[1:0], 3'b000};
        lanes    = is32 ? 4'hF : is16 ? (A[1] ? 4'hC : 4'h3) : 4'b0001 << A[1:0];
        wdata    = Q << sh;
        wr       = !WEN;
        ram_we   = wr & !periph & !misal;
        push_req = wr & periph & (A[3:2] == 2'd0);
        st_wr    = wr & periph & (A[3:2] == 2'd1);
        tm_wr    = wr & periph & (A[3:2] == 2'd2);
        gp_wr    = wr & periph & (A[3:2] == 2'd3);
        empty    = cnt == 3'd0;
        full     = cnt == 3'(FIFO_DEPTH);
        pop      = !empty & TX_READY;
        push     = push_req & (!full | pop);
        // a set event in the same cycle as its W1C clear keeps the flag set
        ovf_n    = (push_req & full & !pop) | (ovf & !(st_wr & Q[5]));
        mis_n    = (wr & !periph & misal) | (mis & !(st_wr & Q[6]));
        head     = empty ? 32'd0 : fifo[rp];
        status   = {25'd0, mis, ovf, empty, full, cnt};
        rword    = ram[widx];
        rsh      = rword >> sh;
        ram_d    = misal ? 32'd0 : is32 ? rword : is16 ? {16'd0, rsh[15:0]} : {24'd0, rsh[7:0]};
        D        = !periph ? ram_d : (A[3:2] == 2'd0) ? head : (A[3:2] == 2'd1) ? status :
                   (A[3:2] == 2'd2) ? timer : gpio;
        unused_a = ^A;
    end

    assign TX_DATA  = head;
    assign TX_VALID = !empty;
    assign GPIO     = gpio;
    assign ERR      = ovf | mis;

    always_ff @(posedge CLK) begin
        if (ram_we)
            for (int i = 0; i < 4; i++)
                if (lanes[i]) ram[widx][8*i +: 8] <= wdata[8*i +: 8];
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wp    <= 2'd0;
            rp    <= 2'd0;
            cnt   <= 3'd0;
            timer <= 32'd0;
            gpio  <= 32'd0;
            ovf   <= 1'b0;
            mis   <= 1'b0;
        end else begin
            if (push) begin
                fifo[wp] <= Q;
                wp       <= wp + 2'd1;
            end
            if (pop) rp <= rp + 2'd1;
            cnt   <= cnt + {2'd0, push} - {2'd0, pop};
            timer <= tm_wr ? Q : timer + 32'd1;
            if (gp_wr) gpio <= Q;
            ovf   <= ovf_n;
            mis   <= mis_n;
        end
    end
endmodule

// File: tb/tb_sub86_dbus.sv
// tb_sub86_dbus: directed self-checking bench for sub86_dbus.
module tb_sub86_dbus;
    logic        CLK = 1'b0, RSTN = 1'b0, WEN = 1'b1, TX_READY = 1'b0, TX_VALID, ERR;
    logic [31:0] A = 32'd0, Q = 32'd0, D, TX_DATA, GPIO;
    logic [1:0]  BEN = 2'b01;
    int          tests = 0, fails = 0;

    localparam logic [31:0] TXD = 32'hF000_0000, STS = 32'hF000_0004, TMR = 32'hF000_0008, GPR = 32'hF000_000C;

    sub86_dbus dut (.CLK(CLK), .RSTN(RSTN), .A(A), .Q(Q), .WEN(WEN), .BEN(BEN), .D(D),
                    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .GPIO(GPIO), .ERR(ERR));

    always #5 CLK = ~CLK;

    task automatic wr(input logic [31:0] a, input logic [31:0] q, input logic [1:0] b);
        A = a; Q = q; BEN = b; WEN = 1'b0;
        @(posedge CLK); #1;
        WEN = 1'b1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] b);
        A = a; BEN = b; WEN = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        tests++; if (TX_VALID !== 1'b0) begin fails++; $display("FAIL rst_valid got %h exp 0", TX_VALID); end
        tests++; if (TX_DATA !== 32'd0) begin fails++; $display("FAIL rst_txdata got %h exp 0", TX_DATA); end
        tests++; if (GPIO !== 32'd0) begin fails++; $display("FAIL rst_gpio got %h exp 0", GPIO); end
        tests++; if (ERR !== 1'b0) begin fails++; $display("FAIL rst_err got %h exp 0", ERR); end
        rd(STS, 2'b01);
        tests++; if (D !== 32'h10) begin fails++; $display("FAIL rst_status got %h exp 00000010", D); end
        rd(TMR, 2'b01);
        tests++; if (D !== 32'd0) begin fails++; $display("FAIL rst_timer got %h exp 0", D); end
    endtask

    task automatic test_ram_sizes;
        wr(32'h100, 32'h1122_3344, 2'b01);
        rd(32'h101, 2'b00);
        tests++; if (D !== 32'h33) begin fails++; $display("FAIL ram_b1 got %h exp 00000033", D); end
        rd(32'h102, 2'b11);
        tests++; if (D !== 32'h1122) begin fails++; $display("FAIL ram_h2 got %h exp 00001122", D); end
        rd(32'h100, 2'b11);
        tests++; if (D !== 32'h3344) begin fails++; $display("FAIL ram_h0 got %h exp 00003344", D); end
        wr(32'h103, 32'hAA, 2'b10);
        rd(32'h100, 2'b01);
        tests++; if (D !== 32'hAA22_3344) begin fails++; $display("FAIL ram_w_after_b got %h exp aa223344", D); end
        rd(32'h1100, 2'b01);
        tests++; if (D !== 32'hAA22_3344) begin fails++; $display("FAIL ram_wrap got %h exp aa223344", D); end
        wr(32'h106, 32'hBEEF, 2'b11);
        rd(32'h104, 2'b01);
        tests++; if (D[31:16] !== 16'hBEEF) begin fails++; $display("FAIL ram_h_upper got %h exp beef", D[31:16]); end
    endtask

    task automatic test_misalign;
        wr(32'h102, 32'hFFFF_FFFF, 2'b01);
        rd(32'h100, 2'b01);
        tests++; if (D !== 32'hAA22_3344) begin fails++; $display("FAIL mis_ram_kept got %h exp aa223344", D); end
        rd(32'h101, 2'b01);
        tests++; if (D !== 32'd0) begin fails++; $display("FAIL mis_read got %h exp 0", D); end
        rd(STS, 2'b01);
        tests++; if (D !== 32'h50) begin fails++; $display("FAIL mis_status got %h exp 00000050", D); end
        tests++; if (ERR !== 1'b1) begin fails++; $display("FAIL mis_err got %h exp 1", ERR); end
        wr(STS, 32'h40, 2'b01);
        rd(STS, 2'b01);
        tests++; if (D !== 32'h10) begin fails++; $display("FAIL mis_clear got %h exp 00000010", D); end
        tests++; if (ERR !== 1'b0) begin fails++; $display("FAIL mis_err_clr got %h exp 0", ERR); end
    endtask

    task automatic test_fifo_overflow;
        TX_READY = 1'b0;
        for (int i = 1; i <= 4; i++) wr(TXD, i, 2'b01);
        rd(STS, 2'b01);
        tests++; if (D !== 32'h0C) begin fails++; $display("FAIL ff_full got %h exp 0000000c", D); end
        tests++; if (TX_VALID !== 1'b1 || TX_DATA !== 32'd1) begin fails++; $display("FAIL ff_head got %h/%h exp 1/00000001", TX_VALID, TX_DATA); end
        wr(TXD, 32'd5, 2'b01);
        rd(STS, 2'b01);
        tests++; if (D !== 32'h2C) begin fails++; $display("FAIL ff_ovf got %h exp 0000002c", D); end
        tests++; if (ERR !== 1'b1) begin fails++; $display("FAIL ff_err got %h exp 1", ERR); end
        TX_READY = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tests++; if (TX_DATA !== 32'(i)) begin fails++; $display("FAIL ff_drain%0d got %h exp %h", i, TX_DATA, 32'(i)); end
            @(posedge CLK); #1;
        end
        TX_READY = 1'b0;
        tests++; if (TX_VALID !== 1'b0) begin fails++; $display("FAIL ff_empty_valid got %h exp 0", TX_VALID); end
        rd(STS, 2'b01);
        tests++; if (D !== 32'h30) begin fails++; $display("FAIL ff_empty_status got %h exp 00000030", D); end
        wr(STS, 32'h20, 2'b01);
        rd(STS, 2'b01);
        tests++; if (D !== 32'h10) begin fails++; $display("FAIL ff_ovf_clr got %h exp 00000010", D); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q [4] = '{32'd6, 32'd7, 32'd8, 32'd9};
        TX_READY = 1'b0;
        for (int i = 5; i <= 8; i++) wr(TXD, i, 2'b01);
        TX_READY = 1'b1;
        wr(TXD, 32'd9, 2'b01);
        rd(STS, 2'b01);
        tests++; if (D !== 32'h0C) begin fails++; $display("FAIL b2b_count got %h exp 0000000c", D); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (TX_DATA !== exp_q[i]) begin fails++; $display("FAIL b2b_drain%0d got %h exp %h", i, TX_DATA, exp_q[i]); end
            @(posedge CLK); #1;
        end
        tests++; if (TX_VALID !== 1'b0 || ERR !== 1'b0) begin fails++; $display("FAIL b2b_end got %h/%h exp 0/0", TX_VALID, ERR); end
        wr(TXD, 32'h77, 2'b01);
        tests++; if (TX_VALID !== 1'b1 || TX_DATA !== 32'h77) begin fails++; $display("FAIL empty_pushpop got %h/%h exp 1/00000077", TX_VALID, TX_DATA); end
        @(posedge CLK); #1;
        tests++; if (TX_VALID !== 1'b0) begin fails++; $display("FAIL empty_pushpop_pop got %h exp 0", TX_VALID); end
        TX_READY = 1'b0;
    endtask

    task automatic test_timer;
        wr(TMR, 32'hFFFF_FFFE, 2'b01);
        rd(TMR, 2'b01);
        tests++; if (D !== 32'hFFFF_FFFE) begin fails++; $display("FAIL tmr_load got %h exp fffffffe", D); end
        @(posedge CLK); #1;
        tests++; if (D !== 32'hFFFF_FFFF) begin fails++; $display("FAIL tmr_inc got %h exp ffffffff", D); end
        @(posedge CLK); #1;
        tests++; if (D !== 32'd0) begin fails++; $display("FAIL tmr_wrap got %h exp 00000000", D); end
        wr(TMR, 32'hFFFF_FFFE, 2'b01);
        @(posedge CLK); #1;
        wr(TMR, 32'h1234, 2'b01);
        rd(TMR, 2'b01);
        tests++; if (D !== 32'h1234) begin fails++; $display("FAIL tmr_load_wins got %h exp 00001234", D); end
        @(posedge CLK); #1;
        tests++; if (D !== 32'h1235) begin fails++; $display("FAIL tmr_after_load got %h exp 00001235", D); end
    endtask

    task automatic test_gpio;
        wr(GPR, 32'hDEAD_BEEF, 2'b00);
        rd(GPR, 2'b01);
        tests++; if (GPIO !== 32'hDEAD_BEEF || D !== 32'hDEAD_BEEF) begin fails++; $display("FAIL gpio got %h/%h exp deadbeef", GPIO, D); end
    endtask

    task automatic test_reset_mid;
        TX_READY = 1'b0;
        wr(32'h200, 32'hCAFE_F00D, 2'b01);
        wr(TXD, 32'hA1, 2'b01);
        wr(TXD, 32'hA2, 2'b01);
        wr(GPR, 32'h5A, 2'b01);
        wr(32'h102, 32'h0, 2'b01);
        tests++; if (TX_VALID !== 1'b1 || GPIO !== 32'h5A || ERR !== 1'b1) begin fails++; $display("FAIL rmid_pre got %h/%h/%h exp 1/0000005a/1", TX_VALID, GPIO, ERR); end
        #2 RSTN = 1'b0;
        #1;
        tests++; if (TX_VALID !== 1'b0 || GPIO !== 32'd0 || ERR !== 1'b0) begin fails++; $display("FAIL rmid_regs got %h/%h/%h exp 0/00000000/0", TX_VALID, GPIO, ERR); end
        rd(TMR, 2'b01);
        tests++; if (D !== 32'd0) begin fails++; $display("FAIL rmid_timer got %h exp 0", D); end
        rd(STS, 2'b01);
        tests++; if (D !== 32'h10) begin fails++; $display("FAIL rmid_status got %h exp 00000010", D); end
        RSTN = 1'b1;
        rd(32'h200, 2'b01);
        tests++; if (D !== 32'hCAFE_F00D) begin fails++; $display("FAIL rmid_ram got %h exp cafef00d", D); end
    endtask

    initial begin
        #1;
        test_reset;
        repeat (2) @(posedge CLK);
        @(negedge CLK) RSTN = 1'b1;
        @(posedge CLK); #1;
        test_ram_sizes;
        test_misalign;
        test_fifo_overflow;
        test_back_to_back;
        test_timer;
        test_gpio;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
